// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared glyph table, display constants and FSM state type
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} disp_state_t;

  // Active-low {a,b,c,d,e,f,g} pattern for one hex digit
  function automatic logic [6:0] glyph(logic [3:0] d);
    case (d)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  // Decimal digits needed for the largest w-bit value, i.e. ceil(w*log10(2))
  function automatic int bcd_digits(int w);
    longint v;
    int n;
    v = (longint'(1) << w) - 1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (v > 0) begin
        n++;
        v = v / 10;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// bin2bcd_serial: serial double-dabble datapath, one operand bit per step
module bin2bcd_serial
  import seven_seg_pkg::*;
#(
  parameter int IN_W  = 6,
  parameter int BCD_D = bcd_digits(IN_W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [IN_W-1:0]      value,
  output logic [IN_W-1:0]      opnd,
  output logic [4*BCD_D-1:0]   bcd
);

  logic [4*BCD_D-1:0] adj;

  // Add 3 to every nibble >= 5 so the following shift carries correctly into the next decade
  always_comb begin
    adj = bcd;
    for (int i = 0; i < BCD_D; i++)
      adj[4*i+:4] = (bcd[4*i+:4] >= 4'd5) ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
  end

  // Load captures the operand and clears BCD; each step shifts one operand bit into BCD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd <= '0;
      bcd  <= '0;
    end else if (load) begin
      opnd <= value;
      bcd  <= '0;
    end else if (step) begin
      {bcd, opnd} <= {adj, opnd} << 1;
    end
  end

endmodule

// File: rtl/seven_seg_display_driver.sv
// seven_seg_display_driver: binary to hex/decimal active-low seven-segment glyphs with blanking and overflow
module seven_seg_display_driver
  import seven_seg_pkg::*;
#(
  parameter int IN_W   = 6,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       value,
  input  logic                  mode,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [DIGITS*7-1:0]   seg
);

  localparam int BCD_D = bcd_digits(IN_W);
  localparam int CW    = $clog2(IN_W + 1);
  localparam int XW    = 4 * (DIGITS + BCD_D) + IN_W;

  disp_state_t           state;
  logic [CW-1:0]         cnt;
  logic                  mode_r;
  logic                  blz_r;
  logic                  load;
  logic                  step;
  logic [IN_W-1:0]       opnd;
  logic [4*BCD_D-1:0]    bcd;
  logic [XW-1:0]         src;
  logic                  ovf_n;
  logic [DIGITS*7-1:0]   seg_n;

  assign busy = state != IDLE;
  assign load = state == IDLE && start;
  assign step = state == SHIFT;

  bin2bcd_serial #(.IN_W(IN_W), .BCD_D(BCD_D)) u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .value (value),
    .opnd  (opnd),
    .bcd   (bcd)
  );

  // Digit source widened so overflow is simply "anything above the displayed nibbles is set"
  always_comb begin
    src   = mode_r ? XW'(opnd) : XW'(bcd);
    ovf_n = |(src >> (4 * DIGITS));
    seg_n = '1;
    for (int i = 0; i < DIGITS; i++)
      seg_n[7*i+:7] = ovf_n ? SEG_DASH :
                      (blz_r && i > 0 && (src >> (4 * i)) == '0) ? SEG_BLANK :
                      glyph(src[4*i+:4]);
  end

  // Conversion FSM; seg/ovf/done are registered together in ENCODE so all digits change at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_r <= 1'b0;
      blz_r  <= 1'b0;
      seg    <= '1;
      ovf    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mode_r <= mode;
          blz_r  <= blank_lz;
          cnt    <= '0;
          state  <= mode ? ENCODE : SHIFT;
        end
        SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(IN_W - 1)) state <= ENCODE;
        end
        ENCODE: begin
          seg   <= seg_n;
          ovf   <= ovf_n;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
